// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game geometry and obstacle FSM state type
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        MOVE = 2'd2,
        HIT  = 2'd3
    } state_t;

    localparam logic [15:0] SCREEN_W = 16'd640;
    localparam logic [15:0] GROUND_Y = 16'd400;
    localparam logic [15:0] PLAYER_W = 16'd20;
    localparam logic [15:0] PLAYER_H = 16'd20;

endpackage

// File: rtl/rect_overlap.sv
// rtl/rect_overlap.sv - combinational half-open rectangle overlap test
// Right/bottom edges are formed in 17 bits so boxes near 16'hFFFF do not wrap.
module rect_overlap (
    input  logic [15:0] a_x,
    input  logic [15:0] a_y,
    input  logic [15:0] a_w,
    input  logic [15:0] a_h,
    input  logic [15:0] b_x,
    input  logic [15:0] b_y,
    input  logic [15:0] b_w,
    input  logic [15:0] b_h,
    output logic        overlap
);

    logic [16:0] a_x_end;
    logic [16:0] a_y_end;
    logic [16:0] b_x_end;
    logic [16:0] b_y_end;

    always_comb begin
        a_x_end = {1'b0, a_x} + {1'b0, a_w};
        a_y_end = {1'b0, a_y} + {1'b0, a_h};
        b_x_end = {1'b0, b_x} + {1'b0, b_w};
        b_y_end = {1'b0, b_y} + {1'b0, b_h};
        overlap = ({1'b0, a_x} < b_x_end) && ({1'b0, b_x} < a_x_end) &&
                  ({1'b0, a_y} < b_y_end) && ({1'b0, b_y} < a_y_end);
    end

endmodule

// File: rtl/obstacle_ctrl.sv
// rtl/obstacle_ctrl.sv - single ground obstacle: spawn, scroll, collide, score
// Also produces the registered obstacle pixel flag for the VGA colour mux.
module obstacle_ctrl
    import game_pkg::*;
#(
    parameter int OBS_W         = 16,
    parameter int OBS_H         = 24,
    parameter int SPEED         = 2,
    parameter int GAP_MIN       = 200,
    parameter int GAP_RAND_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1ms,
    input  logic        start,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] x_player,
    input  logic [15:0] y_player,
    output logic [15:0] obs_x,
    output logic [15:0] obs_y,
    output logic        obs_pixel,
    output logic        hit,
    output logic [15:0] score
);

    localparam logic [15:0] OBS_W16   = 16'(OBS_W);
    localparam logic [15:0] OBS_H16   = 16'(OBS_H);
    localparam logic [15:0] SPEED16   = 16'(SPEED);
    localparam logic [15:0] GAP_MIN16 = 16'(GAP_MIN);
    localparam logic [15:0] OBS_Y     = GROUND_Y + PLAYER_H - OBS_H16;
    // A zero-width random field collapses to a zero mask, i.e. a fixed gap.
    localparam logic [7:0]  RAND_MASK = 8'((1 << GAP_RAND_BITS) - 1);
    localparam logic [7:0]  LFSR_SEED = 8'hA5;

    state_t      state_q,     state_d;
    logic [15:0] obs_x_q,     obs_x_d;
    logic        obs_pixel_q, obs_pixel_d;
    logic        hit_q,       hit_d;
    logic [15:0] score_q,     score_d;
    logic [7:0]  lfsr_q,      lfsr_d;
    logic [15:0] gap_cnt_q,   gap_cnt_d;
    logic        passed_q,    passed_d;

    logic        collision;
    logic        scan_in;
    logic        cleared;
    logic [15:0] gap_reload;

    rect_overlap u_collide (
        .a_x     (obs_x_q),
        .a_y     (OBS_Y),
        .a_w     (OBS_W16),
        .a_h     (OBS_H16),
        .b_x     (x_player),
        .b_y     (y_player),
        .b_w     (PLAYER_W),
        .b_h     (PLAYER_H),
        .overlap (collision)
    );

    // The scan point is treated as a 1x1 box so the same overlap test applies.
    rect_overlap u_scan (
        .a_x     (obs_x_q),
        .a_y     (OBS_Y),
        .a_w     (OBS_W16),
        .a_h     (OBS_H16),
        .b_x     (x),
        .b_y     (y),
        .b_w     (16'd1),
        .b_h     (16'd1),
        .overlap (scan_in)
    );

    always_comb begin
        state_d     = state_q;
        obs_x_d     = obs_x_q;
        hit_d       = hit_q;
        score_d     = score_q;
        gap_cnt_d   = gap_cnt_q;
        passed_d    = passed_q;
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        gap_reload  = GAP_MIN16 + {8'd0, lfsr_q & RAND_MASK};
        cleared     = ({1'b0, obs_x_q} + {1'b0, OBS_W16}) <= {1'b0, x_player};
        obs_pixel_d = ((state_q == MOVE) || (state_q == HIT)) && scan_in;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = GAP;
                    gap_cnt_d = gap_reload;
                end
            end
            GAP: begin
                if (tick_1ms) begin
                    if (gap_cnt_q == 16'd0) begin
                        state_d  = MOVE;
                        obs_x_d  = SCREEN_W;
                        passed_d = 1'b0;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 16'd1;
                    end
                end
            end
            MOVE: begin
                // A collision freezes everything else in the same cycle.
                if (collision) begin
                    state_d = HIT;
                    hit_d   = 1'b1;
                end else begin
                    if (cleared && !passed_q) begin
                        passed_d = 1'b1;
                        if (score_q != 16'hFFFF) begin
                            score_d = score_q + 16'd1;
                        end
                    end
                    if (tick_1ms) begin
                        if (obs_x_q < SPEED16) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_reload;
                            obs_x_d   = SCREEN_W;
                        end else begin
                            obs_x_d = obs_x_q - SPEED16;
                        end
                    end
                end
            end
            HIT: begin
                if (start) begin
                    state_d   = GAP;
                    hit_d     = 1'b0;
                    score_d   = 16'd0;
                    obs_x_d   = SCREEN_W;
                    gap_cnt_d = gap_reload;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            obs_x_q     <= SCREEN_W;
            obs_pixel_q <= 1'b0;
            hit_q       <= 1'b0;
            score_q     <= 16'd0;
            lfsr_q      <= LFSR_SEED;
            gap_cnt_q   <= 16'd0;
            passed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            obs_x_q     <= obs_x_d;
            obs_pixel_q <= obs_pixel_d;
            hit_q       <= hit_d;
            score_q     <= score_d;
            lfsr_q      <= lfsr_d;
            gap_cnt_q   <= gap_cnt_d;
            passed_q    <= passed_d;
        end
    end

    assign obs_x     = obs_x_q;
    assign obs_y     = OBS_Y;
    assign obs_pixel = obs_pixel_q;
    assign hit       = hit_q;
    assign score     = score_q;

endmodule

// File: tb/tb_obstacle_ctrl.sv
// tb/tb_obstacle_ctrl.sv - scoreboard bench for obstacle_ctrl against a game-rule model
module tb_obstacle_ctrl;
    import game_pkg::*;

    localparam int SPEED_M = 2;
    localparam int GAP_M   = 3;
    localparam int OW      = 16;
    localparam int OH      = 24;
    localparam int OY      = 400 + 20 - OH;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick_1ms = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = 16'd0;
    logic [15:0] y = 16'd0;
    logic [15:0] x_player = 16'd600;
    logic [15:0] y_player = 16'd300;
    logic [15:0] obs_x;
    logic [15:0] obs_y;
    logic        obs_pixel;
    logic        hit;
    logic [15:0] score;

    obstacle_ctrl #(
        .OBS_W(16), .OBS_H(24), .SPEED(2), .GAP_MIN(3), .GAP_RAND_BITS(0)
    ) dut (
        .clk(clk), .reset(reset), .tick_1ms(tick_1ms), .start(start),
        .x(x), .y(y), .x_player(x_player), .y_player(y_player),
        .obs_x(obs_x), .obs_y(obs_y), .obs_pixel(obs_pixel),
        .hit(hit), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ox;
        int pix;
        int ht;
        int sc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   drv_done = 1'b0;

    // Game-level model: phase 0 waiting for start, 1 counting gap ticks,
    // 2 obstacle on screen, 3 crashed.
    int m_phase = 0;
    int m_wait  = 0;
    int m_x     = 640;
    int m_hit   = 0;
    int m_score = 0;
    int m_clear = 0;
    int m_pix   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int boxes_touch(int ax, int ay, int aw, int ah,
                                       int bx, int by, int bw, int bh);
        return int'(ax < bx + bw && bx < ax + aw && ay < by + bh && by < ay + ah);
    endfunction

    task automatic step(input bit rst, input bit tk, input bit st,
                        input int sx, input int sy, input int px, input int py);
        exp_t e;
        reset    = rst;
        tick_1ms = tk;
        start    = st;
        x        = 16'(sx);
        y        = 16'(sy);
        x_player = 16'(px);
        y_player = 16'(py);
        if (rst) begin
            m_phase = 0; m_x = 640; m_hit = 0; m_score = 0;
            m_wait = 0; m_clear = 0; m_pix = 0;
        end else begin
            m_pix = int'((m_phase >= 2) && boxes_touch(m_x, OY, OW, OH, sx, sy, 1, 1) != 0);
            case (m_phase)
                0: if (st) begin m_phase = 1; m_wait = GAP_M; end
                1: if (tk) begin
                    if (m_wait == 0) begin m_phase = 2; m_x = 640; m_clear = 0; end
                    else m_wait--;
                end
                2: begin
                    if (boxes_touch(m_x, OY, OW, OH, px, py, 20, 20) != 0) begin
                        m_phase = 3; m_hit = 1;
                    end else begin
                        if (m_clear == 0 && m_x + OW <= px) begin
                            m_clear = 1;
                            if (m_score < 65535) m_score++;
                        end
                        if (tk) begin
                            if (m_x < SPEED_M) begin m_phase = 1; m_wait = GAP_M; m_x = 640; end
                            else m_x -= SPEED_M;
                        end
                    end
                end
                default: if (st) begin
                    m_phase = 1; m_wait = GAP_M; m_hit = 0; m_score = 0; m_x = 640;
                end
            endcase
        end
        e.ox = m_x; e.pix = m_pix; e.ht = m_hit; e.sc = m_score;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("obs_x", 32'(obs_x), 32'(e.ox));
                chk("obs_y", 32'(obs_y), 32'(OY));
                chk("obs_pixel", 32'(obs_pixel), 32'(e.pix));
                chk("hit", 32'(hit), 32'(e.ht));
                chk("score", 32'(score), 32'(e.sc));
            end
        end
    end

    initial begin : driver
        int px;
        int py;
        int sx;
        int sy;
        bit tk;
        bit st;
        @(posedge clk);
        #1;
        // Reset from power-up.
        step(1, 0, 0, 0, 0, 600, 300);
        step(1, 0, 0, 0, 0, 600, 300);
        chk("state_after_reset", 32'(dut.state_q), 32'(IDLE));

        // Start, gap of four ticks with idle clocks between, then scroll.
        step(0, 0, 1, 0, 0, 600, 300);
        for (int i = 0; i < 12; i++) step(0, (i % 3) == 0, 0, 0, 0, 600, 300);

        // Player standing in the obstacle path with a tick every clock.
        for (int i = 0; i < 400; i++) step(0, 1, 0, m_x, OY, 200, 400);
        for (int i = 0; i < 5; i++) step(0, 1, 0, m_x + OW, OY, 200, 400);
        step(0, 0, 1, 0, 0, 200, 300);

        // Player lifted above the obstacle: full pass, respawn, second pass.
        for (int i = 0; i < 900; i++) begin
            sx = ((i % 2) == 0) ? m_x : m_x + OW;
            step(0, (i % 2) == 0, 0, sx, OY + (i % 30), 200, 300);
        end

        // Reset while the obstacle is moving.
        while (m_phase != 2) step(0, 1, 0, 0, 0, 600, 300);
        for (int i = 0; i < 10; i++) step(0, 1, 0, m_x, OY, 600, 300);
        step(1, 1, 0, m_x, OY, 600, 300);
        step(1, 1, 0, m_x, OY, 600, 300);
        chk("state_after_mid_reset", 32'(dut.state_q), 32'(IDLE));

        // Randomised play.
        px = 200; py = 400;
        for (int i = 0; i < 15000; i++) begin
            if ((i % 400) == 0) begin
                px = $urandom_range(0, 620);
                case ($urandom_range(0, 2))
                    0: py = 400;
                    1: py = 300;
                    default: py = $urandom_range(370, 425);
                endcase
            end
            tk = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 40) == 0);
            sx = m_x + $urandom_range(0, 20) - 2;
            if (sx < 0) sx = 0;
            sy = $urandom_range(OY - 3, OY + OH + 2);
            step($urandom_range(0, 1999) == 0, tk, st, sx, sy, px, py);
        end

        repeat (3) @(posedge clk);
        drv_done = 1'b1;
    end

    initial begin : finisher
        wait (drv_done);
        #4;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
